// File: rtl/ex_mem_pkg.sv
// Shared types and default widths for the EX/MEM pipeline register.
// payload_t gives the field order used when the stage packs its payload.
package ex_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int WB_W_DEF   = 2;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
  } mem_ctl_t;

  // Field order matches the concatenation packed by ex_mem_pipe.
  typedef struct packed {
    logic [WB_W_DEF-1:0]   wb;
    mem_ctl_t              m;
    logic                  zero;
    logic [DATA_W_DEF-1:0] add;
    logic [DATA_W_DEF-1:0] alu;
    logic [DATA_W_DEF-1:0] rdata2;
    logic [REG_W_DEF-1:0]  rd;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

endpackage

// File: rtl/ex_mem_pipe_skid.sv
// Valid/ready holding stage for an opaque payload.
// EX_MEM_SKID_EN selects a 2-entry skid buffer with registered in_ready.
module pipe_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and data is stable while valid && !ready.
  logic         valid_q;
  logic [W-1:0] data_q;

  assign out_valid = valid_q;
  assign out_data  = data_q;

`ifdef EX_MEM_SKID_EN

  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_q;
  logic         ready_q;
  logic         push, load_out;

  assign in_ready = ready_q;
  assign push     = in_valid && ready_q;
  // Output register may take new data when empty or being popped.
  assign load_out = !valid_q || out_ready;

  always_comb begin
    skid_valid_d = skid_valid_q;
    if (load_out) skid_valid_d = 1'b0;
    else if (push) skid_valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      ready_q      <= 1'b0;
    end else if (flush) begin
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
      if (load_out) begin
        if (skid_valid_q) begin
          data_q  <= skid_q;
          valid_q <= 1'b1;
        end else if (push) begin
          data_q  <= in_data;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end else if (push) begin
        skid_q <= in_data;
      end
    end
  end

`else

  assign in_ready = out_ready || !valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

`endif

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: packs EX results into a handshaked stage and
// gates control outputs into bubbles when empty. Define EX_MEM_SKID_EN for the skid buffer.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int WB_W   = WB_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   ctlwb_in,
  input  logic [2:0]        ctlm_in,
  input  logic [DATA_W-1:0] adder_in,
  input  logic [DATA_W-1:0] aluout_in,
  input  logic [DATA_W-1:0] readdat2_in,
  input  logic              aluzero_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_ctlout,
  output logic              branch,
  output logic              memread,
  output logic              memwrite,
  output logic              zero,
  output logic [DATA_W-1:0] add_result,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] rdata2out,
  output logic [REG_W-1:0]  rd_out,
  output logic              pcsrc
);

  localparam int PW = WB_W + 3 + 1 + 3 * DATA_W + REG_W;

  logic [PW-1:0]     in_pay, out_pay;
  logic [WB_W-1:0]   wb_q;
  mem_ctl_t          m_q;
  logic              zero_q;
  logic [DATA_W-1:0] add_q, alu_q, rd2_q;
  logic [REG_W-1:0]  rd_q;

  assign in_pay = {ctlwb_in, ctlm_in, aluzero_in, adder_in, aluout_in, readdat2_in, rd_in};

  pipe_skid #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pay)
  );

  assign {wb_q, m_q, zero_q, add_q, alu_q, rd2_q, rd_q} = out_pay;

  // Control fields become a bubble when empty; data fields keep their last value.
  assign wb_ctlout  = out_valid ? wb_q : '0;
  assign branch     = out_valid && m_q.branch;
  assign memread    = out_valid && m_q.memread;
  assign memwrite   = out_valid && m_q.memwrite;
  assign pcsrc      = out_valid && m_q.branch && zero_q;
  assign zero       = zero_q;
  assign add_result = add_q;
  assign alu_result = alu_q;
  assign rdata2out  = rd2_q;
  assign rd_out     = rd_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed self-checking bench for ex_mem_pipe (default widths); works with
// or without EX_MEM_SKID_EN. Inputs change 1 time unit after rising edges.
module tb_ex_mem_pipe;
  import ex_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  ctlwb_in = '0;
  logic [2:0]  ctlm_in = '0;
  logic [31:0] adder_in = '0, aluout_in = '0, readdat2_in = '0;
  logic        aluzero_in = 1'b0;
  logic [4:0]  rd_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  wb_ctlout;
  logic        branch, memread, memwrite, zero, pcsrc;
  logic [31:0] add_result, alu_result, rdata2out;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [PAYLOAD_W-1:0] exp_q[$];

  ex_mem_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
    .adder_in(adder_in), .aluout_in(aluout_in), .readdat2_in(readdat2_in),
    .aluzero_in(aluzero_in), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_ctlout(wb_ctlout), .branch(branch), .memread(memread), .memwrite(memwrite),
    .zero(zero), .add_result(add_result), .alu_result(alu_result),
    .rdata2out(rdata2out), .rd_out(rd_out), .pcsrc(pcsrc)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every popped entry must match the oldest expected one
  always @(negedge clk) begin
    payload_t obs;
    if (rst_n && out_valid && out_ready) begin
      obs.wb = wb_ctlout;
      obs.m.branch = branch;
      obs.m.memread = memread;
      obs.m.memwrite = memwrite;
      obs.zero = zero;
      obs.add = add_result;
      obs.alu = alu_result;
      obs.rdata2 = rdata2out;
      obs.rd = rd_out;
      if (exp_q.size() == 0) check("unexpected_out", 128'(obs), 128'(0));
      else check("sb_out", 128'(obs), 128'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present one entry, hold until accepted, return 1 unit after the accepting edge
  task automatic push(input logic [1:0] wb, input logic [2:0] m, input logic z,
                      input logic [31:0] add, input logic [31:0] alu,
                      input logic [31:0] rd2, input logic [4:0] rd);
    payload_t p;
    bit done;
    p.wb = wb;
    p.m = mem_ctl_t'(m);
    p.zero = z;
    p.add = add;
    p.alu = alu;
    p.rdata2 = rd2;
    p.rd = rd;
    ctlwb_in = wb; ctlm_in = m; aluzero_in = z;
    adder_in = add; aluout_in = alu; readdat2_in = rd2; rd_in = rd;
    in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(p);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 0, 1);
  endtask

  initial begin
    // reset
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_wb", wb_ctlout, 0);
    check("rst_pcsrc", pcsrc, 0);
    check("rst_alu", alu_result, 0);
    check("rst_add", add_result, 0);
    check("rst_rd", rd_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // single push, latency 1, then bubble with held data
    out_ready = 1'b1;
    push(2'b01, 3'b010, 1'b0, 32'h40, 32'h1234, 32'h55, 5'd7);
    check("lat_out_valid", out_valid, 1);
    check("lat_alu", alu_result, 32'h1234);
    check("lat_rd", rd_out, 7);
    check("lat_memread", memread, 1);
    tick();
    check("drain_out_valid", out_valid, 0);
    check("bubble_wb", wb_ctlout, 0);
    check("bubble_memread", memread, 0);
    check("hold_alu", alu_result, 32'h1234);

    // taken and not-taken branch
    push(2'b11, 3'b100, 1'b1, 32'h100, 32'h0, 32'h0, 5'd1);
    check("br_pcsrc", pcsrc, 1);
    check("br_branch", branch, 1);
    check("br_add", add_result, 32'h100);
    tick();
    check("br_pcsrc_one_cycle", pcsrc, 0);
    push(2'b11, 3'b100, 1'b0, 32'h200, 32'h5, 32'h0, 5'd2);
    check("nt_pcsrc", pcsrc, 0);
    check("nt_branch", branch, 1);
    tick();

    // stall with two pushes, then release
    out_ready = 1'b0;
    push(2'b10, 3'b000, 1'b0, 32'h1, 32'hA1, 32'hB1, 5'd10);
    fork
      push(2'b10, 3'b000, 1'b0, 32'h2, 32'hA2, 32'hB2, 5'd11);
      begin
        tick();
        check("stall_hold_alu", alu_result, 32'hA1);
        tick();
        tick();
        check("stall_in_ready", in_ready, 0);
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_rd", rd_out, 10);
        out_ready = 1'b1;
      end
    join
    repeat (4) tick();
    check("stall_none_lost", exp_q.size(), 0);

    // flush with a held entry and a simultaneous input
    out_ready = 1'b0;
    push(2'b01, 3'b001, 1'b0, 32'h3, 32'hC0, 32'hC1, 5'd12);
    check("pre_flush_memwrite", memwrite, 1);
    flush = 1'b1;
    ctlwb_in = 2'b01; ctlm_in = 3'b001; aluout_in = 32'hDEAD; rd_in = 5'd13;
    in_valid = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("flush_out_valid", out_valid, 0);
    check("flush_memwrite", memwrite, 0);
    out_ready = 1'b1;
    repeat (3) tick();
    check("flush_dropped", out_valid, 0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    push(2'b11, 3'b110, 1'b1, 32'h77, 32'h88, 32'h99, 5'd20);
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_rst_valid", out_valid, 0);
    check("async_rst_alu", alu_result, 0);
    check("async_rst_rd", rd_out, 0);
    check("async_rst_zero", zero, 0);
    check("async_rst_pcsrc", pcsrc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);

    // 16 back-to-back pushes, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(2'(i), 3'b010, 1'(i), 32'(i * 4), 32'h1000 + 32'(i), 32'(i * 3), 5'(i));
      check("b2b_valid", out_valid, 1);
      check("b2b_alu", alu_result, 32'h1000 + 32'(i));
    end
    repeat (3) tick();
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_idle", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameter DATA_W, default 32, width of add_result, alu_result and rdata2out paths.
REQ-002 Parameter REG_W, default 5, width of the destination-register field.
REQ-003 Parameter WB_W, default 2, width of the write-back control field.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  synchronous kill of all held entries.
REQ-007 in_valid / in_ready  in / out  1 / 1  upstream EX handshake.
REQ-008 ctlwb_in  in  WB_W  write-back control; ctlm_in  in  3  {branch, memread, memwrite}.
REQ-009 adder_in, aluout_in, readdat2_in  in  DATA_W  branch target, ALU result, store data.
REQ-010 aluzero_in  in  1  ALU zero flag; rd_in  in  REG_W  destination register.
REQ-011 out_valid / out_ready  out / in  1 / 1  downstream MEM handshake.
REQ-012 wb_ctlout  out  WB_W; branch, memread, memwrite  out  1 each; zero  out  1.
REQ-013 add_result, alu_result, rdata2out  out  DATA_W; rd_out  out  REG_W.
REQ-014 pcsrc  out  1  taken-branch indication to fetch.

Function
REQ-015 Accept on in_valid && in_ready at a rising edge; accepted entry appears at outputs with out_valid=1 one cycle later (latency 1).
REQ-016 Entry leaves on out_valid && out_ready; without a new entry, out_valid falls next cycle.
REQ-017 While out_valid && !out_ready, all outputs hold stable.
REQ-018 While out_valid=0: wb_ctlout, branch, memread, memwrite, pcsrc forced 0 (bubble); data outputs hold last value.
REQ-019 pcsrc = branch && zero && out_valid, combinational from registered state only.
REQ-020 Flush: at next edge out_valid=0 and all buffered entries discarded; an input handshaking in the same cycle is dropped (flush wins).
REQ-021 Simultaneous pop and push on a full output stage: new entry replaces old, no bubble, throughput 1/cycle.
REQ-022 Ordering strictly FIFO; no entry duplicated or lost except by flush or reset.

Reset
REQ-023 rst_n low: out_valid=0, every output 0, skid empty, in_ready=1 from first edge after release.
REQ-024 Reset mid-transfer discards all entries; no partial entry is emitted after release.

Configuration
REQ-025 Macro EX_MEM_SKID_EN defined: 2-entry skid buffer; in_ready is a register output (= skid empty), no combinational out_ready->in_ready path; stalled output plus input captures into skid; skid drains to output on out_ready.
REQ-026 EX_MEM_SKID_EN undefined: single register stage; in_ready = out_ready || !out_valid (combinational); otherwise identical behaviour.

Structure
REQ-027 Package ex_mem_pkg: mem-control struct typedef {branch, memread, memwrite}, default width constants, payload struct typedef bundling all data fields.
REQ-028 One sub-module pipe_skid, parametrised on payload width, holds valid/ready and skid logic; ex_mem_pipe packs/unpacks payload and derives bubble gating and pcsrc.

Verification
REQ-029 Reset then push aluout_in=32'h1234, rd_in=5'd7, out_ready=1 -> next cycle out_valid=1, alu_result=32'h1234, rd_out=7.
REQ-030 ctlm_in=3'b100, aluzero_in=1 pushed -> pcsrc=1 for exactly one cycle; same with aluzero_in=0 -> pcsrc=0.
REQ-031 out_ready=0 for 3 cycles with 2 pushes (skid build) -> in_ready=0 after second; release -> both entries in order, none lost.
REQ-032 flush asserted with in_valid=1 and a held entry -> next cycle out_valid=0, memwrite=0, dropped input never appears.
REQ-033 rst_n pulsed low mid-stream with out_valid=1 -> all outputs 0 immediately, in_ready=1 after release.
REQ-034 Back-to-back 16 pushes with out_ready=1 -> 16 outputs on consecutive cycles, zero bubbles.
